// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial datapath.
// Purely combinational; no latency, no flow control.
module fullAdder (
  input  logic inA,
  input  logic inB,
  input  logic carryIn,
  output logic sum,
  output logic carryOut
);

  assign sum      = inA ^ inB ^ carryIn;
  assign carryOut = (inA & inB) | (carryIn & (inA ^ inB));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fullAdder stepped LSB-first over WIDTH bits; done WIDTH cycles after accept.
// start only taken while ready=1; requests during RUN/DONE are dropped. Optional SERIAL_ADD_SUB_EN adds opSub.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             carryIn,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             opSub,
`endif
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shift_a_q, shift_b_q, res_q, sum_q;
  logic             carry_q, carry_out_q, ready_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] load_b_d;
  logic             load_c_d;
  logic [WIDTH-1:0] res_d;
  logic             fa_sum, fa_cout;
  logic             unused_res;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is two's complement: invert B and force the initial carry.
  assign load_b_d = opSub ? ~opB : opB;
  assign load_c_d = opSub ? 1'b1 : carryIn;
`else
  assign load_b_d = opB;
  assign load_c_d = carryIn;
`endif

  fullAdder u_fa (
    .inA      (shift_a_q[0]),
    .inB      (shift_b_q[0]),
    .carryIn  (carry_q),
    .sum      (fa_sum),
    .carryOut (fa_cout)
  );

  // Bit 0 of the result register is always shifted out on the final edge.
  assign res_d      = {fa_sum, res_q[WIDTH-1:1]};
  assign unused_res = res_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_a_q   <= '0;
      shift_b_q   <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_a_q <= opA;
            shift_b_q <= load_b_d;
            carry_q   <= load_c_d;
            cnt_q     <= '0;
            res_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          res_q     <= res_d;
          carry_q   <= fa_cout;
          shift_a_q <= shift_a_q >> 1;
          shift_b_q <= shift_b_q >> 1;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sum_q       <= res_d;
            carry_out_q <= fa_cout;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryOut = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); subtract cases need SERIAL_ADD_SUB_EN.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, carryIn;
  logic [W-1:0] opA, opB;
`ifdef SERIAL_ADD_SUB_EN
  logic         opSub;
`endif
  logic         ready, carryOut, done;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .carryIn  (carryIn),
`ifdef SERIAL_ADD_SUB_EN
    .opSub    (opSub),
`endif
    .ready    (ready),
    .sum      (sum),
    .carryOut (carryOut),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation from idle, scrambles inputs after accept, checks latency and result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic ec);
    int n;
    opA = a; opB = b; carryIn = ci; start = 1'b1;
    tick();
    start = 1'b0; opA = 8'($urandom); opB = 8'($urandom); carryIn = 1'($urandom);
    chk({tag, "_ready_low"}, ready, 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, carryOut, ec);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_back"}, ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; carryIn = 1'b0; opA = '0; opB = '0;
`ifdef SERIAL_ADD_SUB_EN
    opSub = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carryOut, 0);
    reset = 1'b0;
    tick();

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

    for (int i = 0; i < 20; i++) begin
      opA = 8'($urandom); opB = 8'($urandom); carryIn = 1'($urandom);
      tick();
      chk("hold_sum", sum, 8'h96);
      chk("hold_cout", carryOut, 0);
    end

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);

    // start held high: accepts at edges 0, 10, 20; off-accept operands are noise.
    start = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (j % 10 == 0) begin
        if (j == 10) begin opA = 8'hC0; opB = 8'h50; end
        else begin opA = 8'h11; opB = 8'h22; end
        carryIn = 1'b0;
      end else begin
        opA = 8'($urandom); opB = 8'($urandom); carryIn = 1'($urandom);
      end
      tick();
      chk("stream_done", done, (j % 10 == 8));
      chk("stream_ready", ready, (j % 10 == 9));
      if (j % 10 == 8) begin
        chk("stream_sum", sum, (j == 18) ? 8'h10 : 8'h33);
        chk("stream_cout", carryOut, (j == 18));
      end
    end
    start = 1'b0;
    tick();

    opA = 8'hAA; opB = 8'h55; carryIn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", carryOut, 0);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("midrst_no_done", done, 0);
    end

    opA = 8'h01; opB = 8'h01; reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_ready", ready, 1);
    chk("rst_start_done", done, 0);

`ifdef SERIAL_ADD_SUB_EN
    opSub = 1'b1;
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    opSub = 1'b0;
    run_op("add_after_sub", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
